// File: rtl/dmem_sram_ctrl.sv
// rtl/dmem_sram_ctrl.sv - CPU data-memory controller for a 16-bit async SRAM (optional macro: DMEM_MISALIGN_ERR_EN)
module dmem_sram_ctrl #(
    parameter int ADDR_W      = 21,
    parameter int XLEN        = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-2:0] sram_a,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        wcnt;
    logic              we_q, sgn_q, word_q, byte_q, odd_q;
    logic [15:0]       whi_q, lo_q;
    logic              dq_oe;
    logic [15:0]       dq_out;
    logic [ADDR_W-2:0] ha_in;
    logic              skip;
    logic              phase_end;
    logic [7:0]        byte_now;
    logic [31:0]       ld_short;
`ifdef DMEM_MISALIGN_ERR_EN
    logic              err_q;
`endif

    // Ready is tied to IDLE and gated by reset so it is low while reset is held
    assign req_ready = rst_n && (state == IDLE);

    assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

    assign phase_end = (wcnt == WAIT_L);

    // Halfword address of the request; words are forced onto a 4-byte boundary,
    // halfwords lose bit 0 simply by taking the halfword address
    always_comb begin
        ha_in = req_addr[ADDR_W-1:1];
        if (req_size[1]) begin
            ha_in[0] = 1'b0;
        end
    end

    // Misaligned requests bypass the SRAM only when error reporting is built in
`ifdef DMEM_MISALIGN_ERR_EN
    always_comb begin
        skip = ((req_size == 2'd1) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
    end
    assign rsp_err = err_q;
`else
    always_comb begin
        skip = 1'b0;
    end
    assign rsp_err = 1'b0;
`endif

    // Extension of a byte/half load taken straight off the bus at the end of ACC_LO
    always_comb begin
        byte_now = odd_q ? sram_dq[15:8] : sram_dq[7:0];
        if (byte_q) begin
            ld_short = {{24{sgn_q & byte_now[7]}}, byte_now};
        end else begin
            ld_short = {{16{sgn_q & sram_dq[15]}}, sram_dq};
        end
    end

    // Sequencer: accepts a request, runs one or two SRAM phases, then a one-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wcnt      <= 4'd0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            word_q    <= 1'b0;
            byte_q    <= 1'b0;
            odd_q     <= 1'b0;
            whi_q     <= 16'd0;
            lo_q      <= 16'd0;
            sram_a    <= '0;
            sram_ce_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q   <= req_we;
                        sgn_q  <= req_signed;
                        word_q <= req_size[1];
                        byte_q <= (req_size == 2'd0);
                        odd_q  <= req_addr[0];
                        whi_q  <= req_wdata[31:16];
                        wcnt   <= 4'd0;
`ifdef DMEM_MISALIGN_ERR_EN
                        err_q  <= skip;
`endif
                        if (skip) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= ACC_LO;
                            sram_a    <= ha_in;
                            sram_ce_n <= 1'b0;
                            sram_we_n <= !req_we;
                            sram_oe_n <= req_we;
                            sram_lb_n <= (req_size == 2'd0) && req_addr[0];
                            sram_ub_n <= (req_size == 2'd0) && !req_addr[0];
                            dq_oe     <= req_we;
                            dq_out    <= (req_size == 2'd0) ? {2{req_wdata[7:0]}} : req_wdata[15:0];
                        end
                    end
                end
                ACC_LO: begin
                    if (phase_end) begin
                        lo_q <= sram_dq;
                        wcnt <= 4'd0;
                        if (word_q) begin
                            state  <= ACC_HI;
                            sram_a <= sram_a + {{(ADDR_W-2){1'b0}}, 1'b1};
                            dq_out <= whi_q;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= we_q ? '0 : ld_short;
                            sram_ce_n <= 1'b1;
                            sram_we_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                            sram_lb_n <= 1'b1;
                            sram_ub_n <= 1'b1;
                            dq_oe     <= 1'b0;
                        end
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                ACC_HI: begin
                    if (phase_end) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? '0 : {sram_dq, lo_q};
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        dq_oe     <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// tb/tb_dmem_sram_ctrl.sv - directed table-driven bench for dmem_sram_ctrl with behavioural SRAM models
module tb_dmem_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid0 = 1'b0, valid3 = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [20:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        ready0, rv0, err0, we0n, ce0n, oe0n, lb0n, ub0n;
    logic [31:0] rd0;
    logic [19:0] a0;
    wire  [15:0] dq0;
    logic        ready3, rv3, err3, we3n, ce3n, oe3n, lb3n, ub3n;
    logic [31:0] rd3;
    logic [19:0] a3;
    wire  [15:0] dq3;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem3 [0:255];
    logic        mem_clr = 1'b1;

    int checks = 0;
    int errors = 0;

    logic sel = 1'b0;
    logic        m_ready, m_rv, m_err, m_ce_n, m_oe_n, m_lb_n, m_ub_n;
    logic [31:0] m_rd;
    logic [19:0] m_a;

    always #5 clk = ~clk;

    dmem_sram_ctrl #(.ADDR_W(21), .XLEN(32), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0),
        .sram_a(a0), .sram_dq(dq0), .sram_we_n(we0n), .sram_ce_n(ce0n),
        .sram_oe_n(oe0n), .sram_lb_n(lb0n), .sram_ub_n(ub0n)
    );

    dmem_sram_ctrl #(.ADDR_W(21), .XLEN(32), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3),
        .sram_a(a3), .sram_dq(dq3), .sram_we_n(we3n), .sram_ce_n(ce3n),
        .sram_oe_n(oe3n), .sram_lb_n(lb3n), .sram_ub_n(ub3n)
    );

    // SRAM read drivers
    assign dq0 = (!ce0n && !oe0n && we0n) ? mem0[a0[7:0]] : 16'hzzzz;
    assign dq3 = (!ce3n && !oe3n && we3n) ? mem3[a3[7:0]] : 16'hzzzz;

    // SRAM write models with lane enables
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 16'h0000;
                mem3[i] <= 16'h0000;
            end
        end else begin
            if (!ce0n && !we0n) begin
                if (!lb0n) mem0[a0[7:0]][7:0]  <= dq0[7:0];
                if (!ub0n) mem0[a0[7:0]][15:8] <= dq0[15:8];
            end
            if (!ce3n && !we3n) begin
                if (!lb3n) mem3[a3[7:0]][7:0]  <= dq3[7:0];
                if (!ub3n) mem3[a3[7:0]][15:8] <= dq3[15:8];
            end
        end
    end

    assign m_ready = sel ? ready3 : ready0;
    assign m_rv    = sel ? rv3 : rv0;
    assign m_err   = sel ? err3 : err0;
    assign m_rd    = sel ? rd3 : rd0;
    assign m_a     = sel ? a3 : a0;
    assign m_ce_n  = sel ? ce3n : ce0n;
    assign m_oe_n  = sel ? oe3n : oe0n;
    assign m_lb_n  = sel ? lb3n : lb0n;
    assign m_ub_n  = sel ? ub3n : ub0n;

    // WE and OE must never be low together
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((!we0n && !oe0n) || (!we3n && !oe3n)) begin
                errors++;
                $display("FAIL we_oe_both_low actual we0n=%b oe0n=%b we3n=%b oe3n=%b required never both 0",
                         we0n, oe0n, we3n, oe3n);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic s, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [20:0] ad, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int oe_cyc, output logic a_moved, output logic [19:0] a_first,
                          output logic saw_lb, output logic saw_ub, output logic saw_ce);
        int   cnt;
        logic got;
        sel = s;
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        if (s) valid3 = 1'b1; else valid0 = 1'b1;
        cnt = 0;
        while (!m_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid3 = 1'b0;
        rdata = '0; err = 1'b0; lat = 0; oe_cyc = 0; a_moved = 1'b0; a_first = '0;
        saw_lb = 1'b0; saw_ub = 1'b0; saw_ce = 1'b0; got = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (!m_ce_n) begin
                if (!saw_ce) a_first = m_a;
                else if (m_a != a_first) a_moved = 1'b1;
                saw_ce = 1'b1;
                if (!m_lb_n) saw_lb = 1'b1;
                if (!m_ub_n) saw_ub = 1'b1;
                if (!m_oe_n) oe_cyc++;
            end
            if (m_rv) begin
                got = 1'b1; lat = i; rdata = m_rd; err = m_err;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_timeout actual no rsp_valid required rsp_valid within 60 cycles");
        end
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, m_rv}, 32'd0);
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [20:0] ad;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [31:0] lat;
    } vec_t;

    vec_t tbl [13];

    logic [31:0] r_data;
    logic        r_err, r_moved, r_lb, r_ub, r_ce;
    logic [19:0] r_afirst;
    int          r_lat, r_oe;
    logic [1:0]  hs_sz  [3];
    logic [20:0] hs_ad  [3];
    logic [31:0] hs_exp [3];
    int          acc, nrsp;

    initial begin
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 21'h100, 32'hDEADBEEF, 32'h00000000, 32'd3};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 21'h100, 32'h0,        32'hDEADBEEF, 32'd3};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 21'h101, 32'hABCDEF80, 32'h00000000, 32'd2};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 21'h101, 32'h0,        32'hFFFFFF80, 32'd2};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 21'h101, 32'h0,        32'h00000080, 32'd2};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 21'h100, 32'h0,        32'hFFFFFFEF, 32'd2};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 21'h100, 32'h0,        32'h000080EF, 32'd2};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 21'h100, 32'h0,        32'hFFFF80EF, 32'd2};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 21'h104, 32'h99991234, 32'h00000000, 32'd2};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 21'h104, 32'h0,        32'h00001234, 32'd2};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 21'h108, 32'hCAFEF00D, 32'h00000000, 32'd3};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 21'h108, 32'h0,        32'hCAFEF00D, 32'd3};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 21'h100, 32'h0,        32'hDEAD80EF, 32'd3};

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_ready", {31'd0, ready0}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rv0}, 32'd0);
        chk("rst_rdata", rd0, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        chk("rst_strobes", {27'd0, we0n, ce0n, oe0n, lb0n, ub0n}, 32'h1F);
        chk("rst_addr", {12'd0, a0}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", {31'd0, ready0}, 32'd1);

        // Table-driven transactions on the zero-wait instance
        for (int i = 0; i < 13; i++) begin
            do_req(1'b0, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].ad, tbl[i].wd,
                   r_data, r_err, r_lat, r_oe, r_moved, r_afirst, r_lb, r_ub, r_ce);
            chk($sformatf("vec%0d_rdata", i), r_data, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), r_lat, tbl[i].lat);
            chk($sformatf("vec%0d_err", i), {31'd0, r_err}, 32'd0);
            if (i == 2) begin
                chk("byte_store_lanes", {30'd0, r_lb, r_ub}, 32'b01);
                chk("byte_store_addr", {12'd0, r_afirst}, 32'h080);
            end
        end
        chk("mem_080", {16'd0, mem0[8'h80]}, 32'h80EF);
        chk("mem_081", {16'd0, mem0[8'h81]}, 32'hDEAD);
        chk("mem_082", {16'd0, mem0[8'h82]}, 32'h1234);
        chk("mem_084", {16'd0, mem0[8'h84]}, 32'hF00D);
        chk("mem_085", {16'd0, mem0[8'h85]}, 32'hCAFE);

        // Back-to-back requests with req_valid held high
        hs_sz[0] = 2'd2; hs_ad[0] = 21'h100; hs_exp[0] = 32'hDEAD80EF;
        hs_sz[1] = 2'd1; hs_ad[1] = 21'h104; hs_exp[1] = 32'h00001234;
        hs_sz[2] = 2'd0; hs_ad[2] = 21'h100; hs_exp[2] = 32'h000000EF;
        sel = 1'b0;
        @(posedge clk);
        #1;
        req_we = 1'b0; req_signed = 1'b0; req_size = hs_sz[0]; req_addr = hs_ad[0];
        valid0 = 1'b1;
        acc = 0;
        nrsp = 0;
        for (int c = 0; c < 60 && nrsp < 3; c++) begin
            @(negedge clk);
            if (rv0) begin
                chk($sformatf("hs_rsp%0d_rdata", nrsp), rd0, hs_exp[nrsp]);
                chk("hs_ready_in_resp", {31'd0, ready0}, 32'd0);
                nrsp++;
            end
            if (ready0 && valid0) begin
                acc++;
                @(posedge clk);
                #1;
                if (acc < 3) begin
                    req_size = hs_sz[acc];
                    req_addr = hs_ad[acc];
                end else begin
                    valid0 = 1'b0;
                end
            end
        end
        valid0 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rv0) nrsp++;
        end
        chk("hs_accepts", acc, 32'd3);
        chk("hs_responses", nrsp, 32'd3);

        // Misaligned word load
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 21'h102, 32'h0,
               r_data, r_err, r_lat, r_oe, r_moved, r_afirst, r_lb, r_ub, r_ce);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("misalign_err", {31'd0, r_err}, 32'd1);
        chk("misalign_rdata", r_data, 32'd0);
        chk("misalign_latency", r_lat, 32'd1);
        chk("misalign_no_strobe", {31'd0, r_ce}, 32'd0);
`else
        chk("misalign_err", {31'd0, r_err}, 32'd0);
        chk("misalign_rdata", r_data, 32'hDEAD80EF);
        chk("misalign_latency", r_lat, 32'd3);
`endif

        // Wait states on the WAIT_CYCLES=3 instance
        do_req(1'b1, 1'b1, 2'd1, 1'b0, 21'h104, 32'h00005A5A,
               r_data, r_err, r_lat, r_oe, r_moved, r_afirst, r_lb, r_ub, r_ce);
        chk("w3_store_latency", r_lat, 32'd5);
        chk("w3_mem_082", {16'd0, mem3[8'h82]}, 32'h5A5A);
        do_req(1'b1, 1'b0, 2'd1, 1'b0, 21'h104, 32'h0,
               r_data, r_err, r_lat, r_oe, r_moved, r_afirst, r_lb, r_ub, r_ce);
        chk("w3_load_rdata", r_data, 32'h00005A5A);
        chk("w3_load_latency", r_lat, 32'd5);
        chk("w3_oe_cycles", r_oe, 32'd4);
        chk("w3_addr_stable", {31'd0, r_moved}, 32'd0);
        chk("w3_addr", {12'd0, r_afirst}, 32'h082);
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 21'h104, 32'h0,
               r_data, r_err, r_lat, r_oe, r_moved, r_afirst, r_lb, r_ub, r_ce);
        chk("w3_word_latency", r_lat, 32'd9);
        chk("w3_word_rdata", r_data, 32'h00005A5A);

        // Reset asserted in the middle of a word store
        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_addr = 21'h110; req_wdata = 32'h11112222;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        @(negedge clk);
        chk("midrst_in_access", {31'd0, ce0n}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {27'd0, we0n, ce0n, oe0n, lb0n, ub0n}, 32'h1F);
        chk("midrst_dq_released", {31'd0, u0.dq_oe}, 32'd0);
        chk("midrst_ready", {31'd0, ready0}, 32'd0);
        chk("midrst_addr", {12'd0, a0}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_release", {31'd0, ready0}, 32'd1);
        nrsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv0) nrsp++;
        end
        chk("midrst_no_rsp", nrsp, 32'd0);
        chk("midrst_no_write", {16'd0, mem0[8'h88]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
